// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - button/event inputs and status outputs of the game sequencer
//
// Purpose: groups every non-clock, non-reset signal of game_sequencer.
// Ports (from the sequencer's point of view, modport slave):
//   in : start_btn, pause_btn   debounced button levels
//   in : apple_eaten            one-cycle eat pulse from the playfield datapath
//   in : collision              collision level from the position controller
//   out: move_tick              one-cycle step pulse
//   out: game_state[1:0]        IDLE=00 RUN=01 PAUSE=10 OVER=11
//   out: velocity[7:0]          current speed level
//   out: score[19:0], high_score[19:0], apple_count[9:0]
//   out: grow, eat_sound, clear_board   one-cycle pulses
// modport master is the driving side (playfield/test environment).
interface game_sequencer_if;
    logic        start_btn;
    logic        pause_btn;
    logic        apple_eaten;
    logic        collision;
    logic        move_tick;
    logic [1:0]  game_state;
    logic [7:0]  velocity;
    logic [19:0] score;
    logic [19:0] high_score;
    logic [9:0]  apple_count;
    logic        grow;
    logic        eat_sound;
    logic        clear_board;

    modport master (
        output start_btn, pause_btn, apple_eaten, collision,
        input  move_tick, game_state, velocity, score, high_score,
        input  apple_count, grow, eat_sound, clear_board
    );

    modport slave (
        input  start_btn, pause_btn, apple_eaten, collision,
        output move_tick, game_state, velocity, score, high_score,
        output apple_count, grow, eat_sound, clear_board
    );
endinterface

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - snake game control FSM, move timer, scoring and levels
//
// Purpose: runs the IDLE/RUN/PAUSE/OVER game flow, generates the move tick whose
// period shrinks with velocity, and keeps score, high score, apple count and level.
// Ports:
//   clock_100Mhz  in  sole clock, rising edge
//   reset         in  synchronous, active-high
//   bus           game_sequencer_if.slave (buttons, eat/collision in; status, pulses out)
// Configuration: define GAME_SEQ_PAUSE_EN to enable the pause button and PAUSE state.
module game_sequencer #(
    parameter int unsigned TICK_BASE        = 50_000_000,
    parameter int unsigned TICK_STEP        = 5_000_000,
    parameter int unsigned TICK_MIN         = 10_000_000,
    parameter int unsigned VEL_INIT         = 2,
    parameter int unsigned VEL_MAX          = 15,
    parameter int unsigned APPLES_PER_LEVEL = 6
) (
    input  logic               clock_100Mhz,
    input  logic               reset,
    game_sequencer_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    localparam logic [31:0] BASE_C     = 32'(TICK_BASE);
    localparam logic [31:0] STEP_C     = 32'(TICK_STEP);
    localparam logic [31:0] MIN_C      = 32'(TICK_MIN);
    localparam logic [7:0]  VEL_INIT_C = 8'(VEL_INIT);
    localparam logic [7:0]  VEL_MAX_C  = 8'(VEL_MAX);
    localparam logic [7:0]  LVL_LAST_C = 8'(APPLES_PER_LEVEL - 1);
    localparam logic [19:0] SCORE_MAX  = 20'd9999;

    state_t      state_q, state_d;
    logic        enter_run;
    logic        start_q;
    logic        start_edge;
    logic        eat_q;
    logic        eat_capture;
    logic [31:0] tick_cnt;
    logic [31:0] vel_prod;
    logic [31:0] period;
    logic [7:0]  level_cnt;
    logic [7:0]  velocity_q;
    logic [19:0] score_q;
    logic [19:0] high_q;
    logic [9:0]  apple_q;
    logic        move_tick_q, grow_q, eat_sound_q, clear_q;
    logic [8:0]  score_add;
    logic [20:0] score_sum;

    assign start_edge = bus.start_btn & ~start_q;

`ifdef GAME_SEQ_PAUSE_EN
    logic pause_q;
    logic pause_edge;
    assign pause_edge = bus.pause_btn & ~pause_q;
`endif

    // Period = max(BASE - vel*STEP, MIN) without letting the subtraction wrap.
    assign vel_prod = {24'd0, velocity_q} * STEP_C;
    assign period   = (BASE_C > vel_prod && (BASE_C - vel_prod) > MIN_C)
                      ? (BASE_C - vel_prod) : MIN_C;

    // Eats are captured here and applied one cycle later, so a reset arriving
    // in between discards them.
    assign eat_capture = (state_q == ST_RUN) & bus.apple_eaten & ~bus.collision;

    assign score_add = (velocity_q < 8'd6) ? {1'b0, velocity_q} : {velocity_q, 1'b0};
    assign score_sum = {1'b0, score_q} + {12'd0, score_add};

    always_comb begin
        state_d   = state_q;
        enter_run = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_edge) begin
                    state_d   = ST_RUN;
                    enter_run = 1'b1;
                end
            end
            ST_RUN: begin
                // Collision outranks a simultaneous pause; start is ignored here.
                if (bus.collision)
                    state_d = ST_OVER;
`ifdef GAME_SEQ_PAUSE_EN
                else if (pause_edge)
                    state_d = ST_PAUSE;
`endif
            end
`ifdef GAME_SEQ_PAUSE_EN
            ST_PAUSE: begin
                if (pause_edge)
                    state_d = ST_RUN;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            start_q     <= bus.start_btn;
            eat_q       <= 1'b0;
            tick_cnt    <= 32'd0;
            level_cnt   <= 8'd0;
            velocity_q  <= VEL_INIT_C;
            score_q     <= 20'd0;
            high_q      <= 20'd0;
            apple_q     <= 10'd0;
            move_tick_q <= 1'b0;
            grow_q      <= 1'b0;
            eat_sound_q <= 1'b0;
            clear_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= bus.start_btn;
            eat_q       <= eat_capture;
            move_tick_q <= 1'b0;
            grow_q      <= 1'b0;
            eat_sound_q <= 1'b0;
            clear_q     <= enter_run;

            if (score_q > high_q)
                high_q <= score_q;

            if (enter_run) begin
                tick_cnt   <= 32'd0;
                level_cnt  <= 8'd0;
                velocity_q <= VEL_INIT_C;
                score_q    <= 20'd0;
                apple_q    <= 10'd0;
            end else begin
                if (state_q == ST_RUN) begin
                    // >= keeps the counter bounded if velocity shortens the period.
                    if (tick_cnt >= period - 32'd1) begin
                        tick_cnt    <= 32'd0;
                        move_tick_q <= 1'b1;
                    end else begin
                        tick_cnt <= tick_cnt + 32'd1;
                    end
                end

                if (eat_q) begin
                    grow_q      <= 1'b1;
                    eat_sound_q <= 1'b1;
                    if (apple_q != 10'd1023)
                        apple_q <= apple_q + 10'd1;
                    score_q <= (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[19:0];
                    // Velocity bump happens after this eat is scored at the old velocity.
                    if (level_cnt >= LVL_LAST_C) begin
                        level_cnt <= 8'd0;
                        if (velocity_q < VEL_MAX_C)
                            velocity_q <= velocity_q + 8'd1;
                    end else begin
                        level_cnt <= level_cnt + 8'd1;
                    end
                end
            end
        end
    end

`ifdef GAME_SEQ_PAUSE_EN
    always_ff @(posedge clock_100Mhz) begin
        pause_q <= bus.pause_btn;
    end
`endif

    assign bus.game_state  = state_q;
    assign bus.move_tick   = move_tick_q;
    assign bus.velocity    = velocity_q;
    assign bus.score       = score_q;
    assign bus.high_score  = high_q;
    assign bus.apple_count = apple_q;
    assign bus.grow        = grow_q;
    assign bus.eat_sound   = eat_sound_q;
    assign bus.clear_board = clear_q;
endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed self-checking bench for game_sequencer
module tb_game_sequencer;
    logic clock_100Mhz = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    game_sequencer_if bus ();

    game_sequencer #(
        .TICK_BASE(20), .TICK_STEP(2), .TICK_MIN(4),
        .VEL_INIT(2), .VEL_MAX(15), .APPLES_PER_LEVEL(6)
    ) dut (
        .clock_100Mhz(clock_100Mhz),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock_100Mhz = ~clock_100Mhz;

    task automatic step();
        @(posedge clock_100Mhz);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Cycles until the next move_tick; 200 means the bound expired.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (bus.move_tick !== 1'b1 && n < 200);
    endtask

    task automatic eat();
        bus.apple_eaten = 1'b1;
        step();
        bus.apple_eaten = 1'b0;
        step();
    endtask

    initial begin
        int n;
        int eats;
        logic [19:0] prev;

        reset           = 1'b1;
        bus.start_btn   = 1'b0;
        bus.pause_btn   = 1'b0;
        bus.apple_eaten = 1'b0;
        bus.collision   = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_state", bus.game_state, 2'b00);
        check("rst_velocity", bus.velocity, 8'd2);
        check("rst_score", bus.score, 0);
        check("rst_high", bus.high_score, 0);
        check("rst_apples", bus.apple_count, 0);
        check("rst_tick", bus.move_tick, 0);
        check("rst_clear", bus.clear_board, 0);

        // Start: clear_board with RUN, then ticks every 16 cycles (20 - 2*2).
        bus.start_btn = 1'b1;
        step();
        bus.start_btn = 1'b0;
        check("start_state", bus.game_state, 2'b01);
        check("start_clear", bus.clear_board, 1);
        wait_tick(n);
        check("first_tick_cycles", n, 16);
        check("clear_one_cycle", bus.clear_board, 0);
        wait_tick(n);
        check("second_tick_cycles", n, 16);

        // First eat: grow/sound one cycle after capture, score +2.
        bus.apple_eaten = 1'b1;
        step();
        bus.apple_eaten = 1'b0;
        check("eat_grow_latency", bus.grow, 0);
        step();
        check("eat_grow", bus.grow, 1);
        check("eat_sound", bus.eat_sound, 1);
        check("eat1_score", bus.score, 2);
        step();
        check("grow_one_cycle", bus.grow, 0);
        for (int i = 0; i < 5; i++) eat();
        check("eat6_score", bus.score, 12);
        check("eat6_apples", bus.apple_count, 6);
        check("eat6_velocity", bus.velocity, 3);
        wait_tick(n);
        wait_tick(n);
        check("period_vel3", n, 14);
        eat();
        check("eat7_score", bus.score, 15);

        // Eat and collision together: collision wins.
        bus.apple_eaten = 1'b1;
        bus.collision   = 1'b1;
        step();
        bus.apple_eaten = 1'b0;
        bus.collision   = 1'b0;
        check("collide_state", bus.game_state, 2'b11);
        step();
        check("collide_score", bus.score, 15);
        check("collide_grow", bus.grow, 0);
        check("collide_sound", bus.eat_sound, 0);
        check("over_high", bus.high_score, 15);
        eat();
        step();
        check("over_eat_ignored", bus.score, 15);
        check("over_apples", bus.apple_count, 7);

        // Restart, then drive score into saturation.
        bus.start_btn = 1'b1;
        step();
        bus.start_btn = 1'b0;
        check("restart_score", bus.score, 0);
        check("restart_velocity", bus.velocity, 2);
        check("restart_high", bus.high_score, 15);
        eats = 0;
        prev = 20'd0;
        for (int i = 0; i < 2000; i++) begin
            bus.apple_eaten = 1'b1;
            step();
            bus.apple_eaten = 1'b0;
            prev = bus.score;
            step();
            eats++;
            if (bus.score == 20'd9999) break;
        end
        check("sat_score", bus.score, 9999);
        check("high_lags_score", bus.high_score, prev);
        step();
        check("sat_high", bus.high_score, 9999);
        check("sat_velocity", bus.velocity, 15);
        check("sat_apples", bus.apple_count, eats);
        eat();
        check("sat_hold", bus.score, 9999);

        // Start ignored while running.
        bus.start_btn = 1'b1;
        step();
        bus.start_btn = 1'b0;
        check("start_in_run_state", bus.game_state, 2'b01);
        check("start_in_run_score", bus.score, 9999);

        bus.collision = 1'b1;
        step();
        bus.collision = 1'b0;
        bus.start_btn = 1'b1;
        step();
        bus.start_btn = 1'b0;
        check("restart2_state", bus.game_state, 2'b01);
        check("restart2_score", bus.score, 0);
        check("restart2_high", bus.high_score, 9999);

`ifdef GAME_SEQ_PAUSE_EN
        for (int i = 0; i < 4; i++) step();
        bus.pause_btn = 1'b1;
        step();
        bus.pause_btn = 1'b0;
        check("pause_state", bus.game_state, 2'b10);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.move_tick === 1'b1) n++;
        end
        check("paused_no_tick", n, 0);
        bus.pause_btn = 1'b1;
        step();
        bus.pause_btn = 1'b0;
        check("resume_state", bus.game_state, 2'b01);
        wait_tick(n);
        check("resume_remaining", n, 11);
`else
        bus.pause_btn = 1'b1;
        step();
        bus.pause_btn = 1'b0;
        step();
        check("pause_disabled", bus.game_state, 2'b01);
`endif

        // Reset right after an eat capture: eat discarded, start held through reset.
        eat();
        bus.apple_eaten = 1'b1;
        step();
        bus.apple_eaten = 1'b0;
        check("pre_reset_grow", bus.grow, 0);
        reset         = 1'b1;
        bus.start_btn = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_grow", bus.grow, 0);
        check("midrst_state", bus.game_state, 2'b00);
        check("midrst_score", bus.score, 0);
        check("midrst_high", bus.high_score, 0);
        check("midrst_velocity", bus.velocity, 2);
        check("midrst_apples", bus.apple_count, 0);
        check("midrst_tick", bus.move_tick, 0);
        step();
        step();
        check("held_start_no_edge", bus.game_state, 2'b00);
        bus.start_btn = 1'b0;
        step();
        bus.start_btn = 1'b1;
        step();
        bus.start_btn = 1'b0;
        check("post_reset_start", bus.game_state, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter TICK_BASE, default 50_000_000, base move period in clock cycles.
REQ-002 Parameter TICK_STEP, default 5_000_000, period reduction per velocity unit.
REQ-003 Parameter TICK_MIN, default 10_000_000, floor on the move period.
REQ-004 Parameter VEL_INIT, default 2, velocity at game start.
REQ-005 Parameter VEL_MAX, default 15, velocity ceiling.
REQ-006 Parameter APPLES_PER_LEVEL, default 6, eats per velocity increment.
REQ-007 Port clock_100Mhz  in  1  sole clock; every flop is on its rising edge.
REQ-008 Port reset  in  1  synchronous, active-high reset.
REQ-009 Port start_btn  in  1  debounced level; the rising edge is detected internally.
REQ-010 Port pause_btn  in  1  debounced level; the rising edge is detected internally.
REQ-011 Port apple_eaten  in  1  one-cycle pulse from the playfield datapath.
REQ-012 Port collision  in  1  level from the position controller.
REQ-013 Port move_tick  out  1  one-cycle pulse that advances the snake one step.
REQ-014 Port game_state  out  2  encoding: IDLE=00, RUN=01, PAUSE=10, OVER=11.
REQ-015 Port velocity  out  8  current speed level.
REQ-016 Port score  out  20  current score.
REQ-017 Port high_score  out  20  best score since reset.
REQ-018 Port apple_count  out  10  apples eaten in the current game.
REQ-019 Port grow  out  1  one-cycle pulse requesting a snake length increment.
REQ-020 Port eat_sound  out  1  one-cycle pulse that triggers the audio block.
REQ-021 Port clear_board  out  1  one-cycle pulse that resets snake, length and apple position.

Function
REQ-022 FSM transitions are:
- IDLE --start edge--> RUN.
- RUN --collision--> OVER.
- RUN --pause edge--> PAUSE.
- PAUSE --pause edge--> RUN.
- OVER --start edge--> RUN.
- All other events leave the state unchanged.
REQ-023 On entry to RUN from IDLE or OVER, in the same cycle, the block SHALL:
- pulse clear_board;
- clear score, apple_count and the level counter to 0;
- load VEL_INIT into velocity;
- clear the tick counter.
REQ-024 Move period SHALL be max(TICK_BASE - velocity*TICK_STEP, TICK_MIN); the arithmetic is 32-bit unsigned with no underflow.
REQ-025 Tick counter:
- increments only in RUN;
- at count == period-1, issues move_tick for one cycle and returns to 0;
- holds its value in PAUSE;
- the period is re-evaluated each cycle from the current velocity.
REQ-026 apple_eaten in RUN with collision low SHALL, registered with 1-cycle latency:
- pulse grow and eat_sound;
- increment apple_count, saturating at 1023;
- add velocity to score if velocity<6, otherwise add 2*velocity;
- saturate score at 9999.
REQ-027 The level counter SHALL count eats from 0 to APPLES_PER_LEVEL-1. On the eat that wraps it to 0, velocity SHALL increment, capped at VEL_MAX, and the new velocity applies from the next eat.
REQ-028 If apple_eaten and collision are high in the same cycle, collision wins: transition to OVER, with no score, grow or sound.
REQ-029 apple_eaten outside RUN SHALL be ignored.
REQ-030 A start edge in RUN or PAUSE SHALL be ignored.
REQ-031 A start edge and a pause edge in the same cycle in RUN SHALL take the pause edge only.
REQ-032 high_score SHALL load score one cycle after score > high_score. It persists across OVER→RUN restarts and is cleared only by reset.
REQ-033 Edge detection SHALL use one registered copy of each button; a button held high through reset produces no edge after reset.

Reset
REQ-034 While reset is high at a clock edge, the block SHALL set:
- game_state = IDLE;
- velocity = VEL_INIT;
- score, high_score, apple_count, level counter and tick counter = 0;
- move_tick, grow, eat_sound and clear_board = 0;
- button edge registers = the current button levels.
REQ-035 Reset asserted mid-game SHALL take effect at the next edge, discarding any pending eat update.

Configuration
REQ-036 Macro GAME_SEQ_PAUSE_EN. When defined, pause behaviour is as in REQ-022 and REQ-025. When undefined:
- pause_btn is ignored;
- PAUSE (10) is unreachable;
- no pause edge logic is synthesized.

Verification
REQ-037 Parameters TICK_BASE=20, TICK_STEP=2, TICK_MIN=4; reset, then a start edge -> game_state=01, clear_board for 1 cycle, first move_tick 16 cycles later, then every 16 cycles.
REQ-038 In RUN, 6 apple_eaten pulses -> score=12, apple_count=6, velocity=3, move period 14; a 7th eat -> score=15.
REQ-039 apple_eaten and collision in the same cycle -> game_state=11; score, grow and eat_sound unchanged.
REQ-040 Drive score past 9999 at velocity≥6 -> score holds 9999; high_score=9999 one cycle later; a start edge -> score=0 and high_score stays 9999.
REQ-041 With GAME_SEQ_PAUSE_EN: pause edge after 5 ticks' worth of counts -> no move_tick while paused; resume -> the tick completes the remaining count. Without the macro: pause edge -> game_state stays 01.
REQ-042 Reset asserted in cycle N of RUN with apple_eaten in cycle N-1 -> all outputs at reset values after edge N, with no grow pulse.
